// File: rtl/des_pkg.sv
// Shared types and constants for the iterative DES sequencing controller.
package des_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } des_ctrl_state_e;

  localparam int unsigned DES_ROUNDS = 16;

  // Per-round key-half rotate amounts; decrypt undoes encrypt in reverse order.
  localparam byte DES_SHIFT_ENC [0:15] = '{
    8'd1, 8'd1, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2,
    8'd1, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 8'd1
  };
  localparam byte DES_SHIFT_DEC [0:15] = '{
    8'd0, 8'd1, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2,
    8'd1, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 8'd1
  };

endpackage

// File: rtl/des_key_shift_rom.sv
// Rotate amount lookup for one DES round, selected by mode.
module des_key_shift_rom
  import des_pkg::*;
(
  input  logic [3:0] round_i,
  input  logic       decrypt_i,
  output logic [1:0] shift_o
);

  always_comb begin
    shift_o = decrypt_i ? 2'(DES_SHIFT_DEC[round_i]) : 2'(DES_SHIFT_ENC[round_i]);
  end

endmodule

// File: rtl/des_round_ctrl.sv
// Sequencing controller for an iterative DES datapath: load, 16 rounds
// (ROUNDS_PER_CYCLE per clock), then a valid/ready result handshake.
module des_round_ctrl
  import des_pkg::*;
#(
  parameter int unsigned ROUNDS_PER_CYCLE = 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic                          decrypt_i,
  input  logic                          flush_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic                          dp_load_o,
  output logic                          dp_round_en_o,
  output logic [3:0]                    dp_round_o,
  output logic [2*ROUNDS_PER_CYCLE-1:0] dp_shift_o,
  output logic                          dp_shift_dir_o,
  output logic                          busy_o
);

  localparam int unsigned NSTEP    = DES_ROUNDS / ROUNDS_PER_CYCLE;
  localparam logic [3:0]  RND_INC  = 4'(ROUNDS_PER_CYCLE);
  localparam logic [3:0]  LAST_RND = 4'((NSTEP - 1) * ROUNDS_PER_CYCLE);

  if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 4)) begin : g_bad_rpc
    $error("des_round_ctrl: ROUNDS_PER_CYCLE must be 1, 2 or 4");
  end

  des_ctrl_state_e state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            mode_q, mode_d;
  logic            accept;
  logic            in_round;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  // Next-state and handshake decode; flush overrides everything.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    mode_d         = mode_q;
    in_ready_o     = 1'b0;
    out_valid_o    = 1'b0;
    dp_round_en_o  = 1'b0;
    dp_round_o     = 4'd0;
    in_round       = 1'b0;
    busy_o         = (state_q != ST_IDLE);
    dp_shift_dir_o = mode_q;

    unique case (state_q)
      ST_IDLE: in_ready_o = 1'b1;
      ST_ROUND: begin
        in_round      = 1'b1;
        dp_round_en_o = 1'b1;
        dp_round_o    = cnt_q;
        if (cnt_q == LAST_RND) begin
          state_d = ST_DONE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + RND_INC;
        end
      end
      ST_DONE: begin
        out_valid_o = 1'b1;
        in_ready_o  = out_ready_i;
        if (out_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    accept    = in_valid_i & in_ready_o & ~flush_i;
    dp_load_o = accept;

    if (flush_i) begin
      state_d = ST_IDLE;
      cnt_d   = 4'd0;
    end else if (accept) begin
      state_d = ST_ROUND;
      cnt_d   = 4'd0;
      mode_d  = decrypt_i;
    end
  end

  // One rotate lookup per unrolled round; slice k serves round cnt_q+k.
  for (genvar k = 0; k < ROUNDS_PER_CYCLE; k++) begin : g_rom
    logic [3:0] rom_idx;
    logic [1:0] rom_shift;

    assign rom_idx = cnt_q + 4'(k);

    des_key_shift_rom u_rom (
      .round_i   (rom_idx),
      .decrypt_i (mode_q),
      .shift_o   (rom_shift)
    );

    assign dp_shift_o[2*k +: 2] = in_round ? rom_shift : 2'b00;
  end

endmodule

// File: tb/tb_des_round_ctrl.sv
// Bench for des_round_ctrl: three instances (1, 2, 4 rounds per clock) on shared
// stimulus, checked every cycle against a transaction-level reference model.
module tb_des_round_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, decrypt = 1'b0, flush = 1'b0, out_ready = 1'b0;

  always #5 clk = ~clk;

  logic       in_ready [3];
  logic       out_valid[3];
  logic       dp_load  [3];
  logic       dp_en    [3];
  logic [3:0] dp_round [3];
  logic       dp_dir   [3];
  logic       busy     [3];
  logic [1:0] shf1;
  logic [3:0] shf2;
  logic [7:0] shf4;

  des_round_ctrl #(.ROUNDS_PER_CYCLE(1)) u_rpc1 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready[0]),
    .decrypt_i(decrypt), .flush_i(flush), .out_valid_o(out_valid[0]), .out_ready_i(out_ready),
    .dp_load_o(dp_load[0]), .dp_round_en_o(dp_en[0]), .dp_round_o(dp_round[0]),
    .dp_shift_o(shf1), .dp_shift_dir_o(dp_dir[0]), .busy_o(busy[0]));

  des_round_ctrl #(.ROUNDS_PER_CYCLE(2)) u_rpc2 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready[1]),
    .decrypt_i(decrypt), .flush_i(flush), .out_valid_o(out_valid[1]), .out_ready_i(out_ready),
    .dp_load_o(dp_load[1]), .dp_round_en_o(dp_en[1]), .dp_round_o(dp_round[1]),
    .dp_shift_o(shf2), .dp_shift_dir_o(dp_dir[1]), .busy_o(busy[1]));

  des_round_ctrl #(.ROUNDS_PER_CYCLE(4)) u_rpc4 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready[2]),
    .decrypt_i(decrypt), .flush_i(flush), .out_valid_o(out_valid[2]), .out_ready_i(out_ready),
    .dp_load_o(dp_load[2]), .dp_round_en_o(dp_en[2]), .dp_round_o(dp_round[2]),
    .dp_shift_o(shf4), .dp_shift_dir_o(dp_dir[2]), .busy_o(busy[2]));

  // Key schedule rotate amounts, written out independently of the RTL package.
  int enc_tab[16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  int dec_tab[16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  // Reference model: one block in flight, counted in completed steps.
  bit pend[3];
  int steps_done[3];
  bit mode[3];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int first_valid[3];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] got_shift(input int i);
    case (i)
      0:       return {6'b0, shf1};
      1:       return {4'b0, shf2};
      default: return shf4;
    endcase
  endfunction

  function automatic int rpc_of(input int i);
    return 1 << i;
  endfunction

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      int r, ns, er;
      bit ir, acc, en, ov;
      logic [7:0] es;
      string sfx;
      r   = rpc_of(i);
      ns  = 16 / r;
      ir  = !pend[i] || (steps_done[i] == ns && out_ready);
      acc = in_valid && ir && !flush;
      en  = pend[i] && steps_done[i] < ns;
      ov  = pend[i] && steps_done[i] == ns;
      er  = en ? steps_done[i] * r : 0;
      es  = 8'd0;
      if (en)
        for (int k = 0; k < r; k++)
          es |= 8'(mode[i] ? dec_tab[er + k] : enc_tab[er + k]) << (2 * k);
      sfx = $sformatf("rpc%0d@%0d", r, cyc);
      chk({"in_ready ", sfx}, 32'(in_ready[i]), 32'(ir));
      chk({"dp_load ", sfx}, 32'(dp_load[i]), 32'(acc));
      chk({"round_en ", sfx}, 32'(dp_en[i]), 32'(en));
      chk({"out_valid ", sfx}, 32'(out_valid[i]), 32'(ov));
      chk({"busy ", sfx}, 32'(busy[i]), 32'(pend[i]));
      chk({"dp_round ", sfx}, 32'(dp_round[i]), 32'(er));
      chk({"dp_shift ", sfx}, 32'(got_shift(i)), 32'(es));
      chk({"shift_dir ", sfx}, 32'(dp_dir[i]), 32'(mode[i]));
    end
  endtask

  task automatic step_model();
    for (int i = 0; i < 3; i++) begin
      int ns;
      bit ir;
      ns = 16 / rpc_of(i);
      ir = !pend[i] || (steps_done[i] == ns && out_ready);
      if (flush) begin
        pend[i] = 1'b0;
        steps_done[i] = 0;
      end else if (in_valid && ir) begin
        pend[i] = 1'b1;
        steps_done[i] = 0;
        mode[i] = decrypt;
      end else if (pend[i] && steps_done[i] < ns) begin
        steps_done[i]++;
      end else if (pend[i] && out_ready) begin
        pend[i] = 1'b0;
      end
    end
  endtask

  task automatic cycle(input bit iv, input bit dec, input bit fl, input bit ordy);
    @(negedge clk);
    in_valid = iv; decrypt = dec; flush = fl; out_ready = ordy;
    #1;
    check_all();
    for (int i = 0; i < 3; i++)
      if (out_valid[i] && first_valid[i] < 0) first_valid[i] = cyc;
    @(posedge clk);
    step_model();
    cyc++;
  endtask

  task automatic reset_checks(input string where);
    for (int i = 0; i < 3; i++) begin
      string sfx;
      sfx = $sformatf("%s rpc%0d", where, rpc_of(i));
      chk({"rst in_ready ", sfx}, 32'(in_ready[i]), 32'd1);
      chk({"rst out_valid ", sfx}, 32'(out_valid[i]), 32'd0);
      chk({"rst dp_load ", sfx}, 32'(dp_load[i]), 32'd0);
      chk({"rst round_en ", sfx}, 32'(dp_en[i]), 32'd0);
      chk({"rst dp_round ", sfx}, 32'(dp_round[i]), 32'd0);
      chk({"rst dp_shift ", sfx}, 32'(got_shift(i)), 32'd0);
      chk({"rst shift_dir ", sfx}, 32'(dp_dir[i]), 32'd0);
      chk({"rst busy ", sfx}, 32'(busy[i]), 32'd0);
    end
  endtask

  // Asynchronous reset pulse asserted mid-cycle, held across one rising edge.
  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    reset_checks("async");
    for (int i = 0; i < 3; i++) begin
      pend[i] = 1'b0; steps_done[i] = 0; mode[i] = 1'b0;
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    cyc++;
  endtask

  task automatic latency_run(input bit dec, input string tag);
    int start;
    for (int i = 0; i < 3; i++) first_valid[i] = -1;
    start = cyc;
    cycle(1'b1, dec, 1'b0, 1'b1);
    repeat (24) cycle(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++)
      chk($sformatf("%s latency rpc%0d", tag, rpc_of(i)), 32'(first_valid[i] - start),
          32'(16 / rpc_of(i) + 1));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      pend[i] = 1'b0; steps_done[i] = 0; mode[i] = 1'b0; first_valid[i] = -1;
    end
    #3;
    reset_checks("power-on");
    @(posedge clk);
    #2 rst_n = 1'b1;

    latency_run(1'b0, "enc");
    latency_run(1'b1, "dec");

    // Back-pressure in DONE, then back-to-back acceptance on release.
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (24) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    repeat (20) cycle(1'b0, 1'b0, 1'b0, 1'b1);

    // Flush at round 7 of the single-round instance: that block never completes.
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (7) cycle(1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) first_valid[i] = -1;
    repeat (20) cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk("flushed block valid rpc1", 32'(first_valid[0]), 32'hFFFF_FFFF);
    latency_run(1'b0, "post-flush");

    // Reset at round 10, then a clean request.
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    repeat (10) cycle(1'b0, 1'b0, 1'b0, 1'b1);
    do_reset();
    latency_run(1'b1, "post-reset");

    // Random traffic with occasional flush and reset.
    repeat (3000) begin
      if ($urandom_range(0, 199) == 0)
        do_reset();
      else
        cycle($urandom_range(0, 99) < 60, 1'($urandom), $urandom_range(0, 99) < 3,
              $urandom_range(0, 99) < 70);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/des_round_ctrl.md
Name: des_round_ctrl

Overview:
- Sequencing controller for an iterative DES datapath (IP, round function, key register, FP).
- Takes one block request per valid/ready handshake.
- Pulses the datapath load strobe, then steps 16 rounds, ROUNDS_PER_CYCLE rounds per clock, driving round index and key-rotate amounts for encrypt or decrypt.
- Presents the result through a valid/ready output handshake, with back-to-back acceptance.

Parameters:
- ROUNDS_PER_CYCLE, 1, rounds the datapath unrolls per clock. Legal values 1, 2, 4; elaboration error otherwise.
- NSTEP, 16/ROUNDS_PER_CYCLE, derived localparam: clocks per block.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; one clock, asynchronous assert, active-low
- in_valid_i  in  1  request valid (block/key on datapath inputs)
- in_ready_o  out  1  controller can accept
- decrypt_i  in  1  mode, sampled on accept (0 encrypt, 1 decrypt)
- flush_i  in  1  synchronous abort
- out_valid_o  out  1  datapath output holds a finished block
- out_ready_i  in  1  consumer accepts
- dp_load_o  out  1  datapath captures IP(block) and PC1(key) this edge
- dp_round_en_o  out  1  datapath advances ROUNDS_PER_CYCLE rounds this edge
- dp_round_o  out  4  index (0..15) of the first round in this step
- dp_shift_o  out  2*ROUNDS_PER_CYCLE  rotate amount per unrolled round; slice k belongs to round dp_round_o+k
- dp_shift_dir_o  out  1  0 = rotate left (encrypt), 1 = rotate right (decrypt)
- busy_o  out  1  state != IDLE

Behaviour:
- Reset values:
  - state IDLE, round counter 0, mode 0.
  - in_ready_o=1; out_valid_o=0, dp_load_o=0, dp_round_en_o=0.
  - dp_round_o=0, dp_shift_o=0, dp_shift_dir_o=0, busy_o=0.
- States: IDLE, ROUND, DONE.
- in_ready_o is (state==IDLE) or (state==DONE and out_ready_i). No other state accepts.
- Accept means in_valid_i & in_ready_o & ~flush_i. The accept edge:
  - dp_load_o is combinational, high in the accept cycle.
  - Mode register takes decrypt_i; counter clears to 0; state goes to ROUND.
- ROUND:
  - dp_round_en_o=1 every cycle; dp_round_o = counter.
  - Counter increments by ROUNDS_PER_CYCLE per edge.
  - In the cycle with counter == 16-ROUNDS_PER_CYCLE, the next state is DONE.
- DONE:
  - out_valid_o=1, held until out_ready_i.
  - out_ready_i without a new accept goes to IDLE.
  - out_ready_i with an accept goes straight to ROUND (back-to-back, no bubble).
- Latency: out_valid_o rises NSTEP edges after the accept edge (16 for RPC=1, 4 for RPC=4).
- Shift table, round r=0..15, all combinational from mode and round index:
  - Encrypt, left rotate: 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - Decrypt, right rotate: 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - dp_shift_dir_o = mode register.
- dp_shift_o outside ROUND is 0. dp_round_en_o and dp_load_o are never both high.
- flush_i, any state: next state IDLE, counter 0, out_valid_o low next cycle. A flushed block is lost and no accept occurs in the flush cycle. A flush in DONE coincident with out_ready_i counts as consumed.
- Reset mid-operation: immediate return to reset values. The datapath contents are don't-care and are never presented.
- in_valid_i may drop before acceptance with no effect. decrypt_i is ignored except on the accept edge.
- Counter width is 4 bits with no wrap: it never exceeds 16-ROUNDS_PER_CYCLE in ROUND.

Decomposition:
- des_pkg:
  - state enum des_ctrl_state_e.
  - Constants DES_ROUNDS=16, DES_SHIFT_ENC[0:15], DES_SHIFT_DEC[0:15] as byte arrays.
- Sub-module des_key_shift_rom:
  - Inputs: round index (4), decrypt (1).
  - Output: shift (2).
  - Instantiated ROUNDS_PER_CYCLE times in a generate loop, with index dp_round_o+k.

Test Plan:
- RPC=1, encrypt, out_ready_i tied 1.
  - Accept at cycle 0: dp_load_o=1 only in cycle 0.
  - dp_round_o steps 0..15 over cycles 1..16, with dp_shift_o sequence 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 and dp_shift_dir_o=0.
  - out_valid_o=1 in cycle 17.
  - With the reference datapath, key 133457799BBCDFF1 and plaintext 0123456789ABCDEF give 85E813540F0AB405.
- RPC=1, decrypt:
  - Shifts 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 with dp_shift_dir_o=1.
  - Ciphertext 85E813540F0AB405 under the same key decrypts to 0123456789ABCDEF.
- RPC=4, encrypt:
  - dp_round_o = 0,4,8,12.
  - dp_shift_o slices {1,1,2,2}, {2,2,2,2}, {1,2,2,2}, {2,2,2,1}.
  - out_valid_o 4 edges after accept.
- Back-pressure and back-to-back:
  - Hold out_ready_i=0 for 5 cycles in DONE: out_valid_o stays 1 and in_ready_o stays 0.
  - Raise out_ready_i with in_valid_i=1: dp_load_o pulses in the same cycle and ROUND starts next cycle.
  - Throughput is one block per 17 cycles at RPC=1.
- flush_i at round 7: IDLE next cycle, out_valid_o never rises for that block, and the next request completes normally.
- rst_ni low at round 10 for 1 cycle, asynchronously: all outputs take reset values immediately, busy_o=0, and a later request completes with correct values.
